shared_bus_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `autoinstparam_first_sub`-style bidirectional port, `a[BITSA:0]`, between up to NREQ requesters. It grants ownership of the port to one requester at a time and drives the selected requester's data onto the shared bus. It inserts a dead turnaround cycle between owners so the inout never sees two drivers. It also enforces a maximum hold time so that a stuck requester cannot starve the others.

---
 rtl/shared_bus_rr_arbiter_pkg.sv | 50 +++++
 rtl/shared_bus_rr_arbiter_pick.sv | 26 ++
 rtl/shared_bus_rr_arbiter.sv | 101 ++++++++++
 tb/tb_shared_bus_rr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shared_bus_rr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the shared-bus arbiter.
// The helper works on a fixed 16-bit request vector sized by a runtime nreq.
package shared_bus_rr_arbiter_pkg;

  localparam int unsigned MAX_NREQ = 16;
  localparam int unsigned PW       = 4;
  localparam int unsigned PW1      = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } arb_state_t;

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } pick_t;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [PW-1:0]       ptr,
                                    input int unsigned         nreq);
    pick_t               r;
    logic [MAX_NREQ-1:0] rot;
    logic [PW:0]         pos;
    logic [PW:0]         off;
    r   = '0;
    rot = '0;
    off = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        pos = {1'b0, ptr} + PW1'(i);
        if (pos >= PW1'(nreq)) pos = pos - PW1'(nreq);
        rot[i] = req[pos[PW-1:0]];
      end
    end
    for (int unsigned i = MAX_NREQ; i > 0; i--) begin
      if (rot[i-1]) begin
        r.found = 1'b1;
        off     = PW1'(i - 1);
      end
    end
    pos = {1'b0, ptr} + off;
    if (pos >= PW1'(nreq)) pos = pos - PW1'(nreq);
    r.idx = pos[PW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/shared_bus_rr_arbiter_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_priority_pick
  import shared_bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [MAX_NREQ-1:0] req_ext;
  pick_t               pick;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    pick              = rr_pick(req_ext, PW'(ptr), NREQ);
    found             = pick.found;
    idx               = IW'(pick.idx);
  end

endmodule

// File: rtl/shared_bus_rr_arbiter.sv
// Round-robin owner sequencer for a shared tri-state port, with a dead
// turnaround cycle between owners and a forced release after MAX_HOLD cycles.
module shared_bus_rr_arbiter
  import shared_bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BITSA    = 7,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             last,
  input  logic [NREQ*(BITSA+1)-1:0]   req_data,
  output logic [NREQ-1:0]             gnt,
  output logic [$clog2(NREQ)-1:0]     gnt_id,
  output logic                        busy,
  output logic [BITSA:0]              bus_a,
  output logic                        bus_oe,
  output logic                        timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned W  = BITSA + 1;

  arb_state_t    state, state_nx;
  logic [IW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          at_max;
  logic          release_own;
  logic          forced;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the current owner's req/last matter; other requesters cannot disturb it.
  always_comb begin
    at_max      = (hold_cnt == HW'(MAX_HOLD));
    release_own = !req[gnt_id] || last[gnt_id] || at_max;
    forced      = at_max && req[gnt_id] && !last[gnt_id];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_found) state_nx = OWN;
      OWN:     if (release_own) state_nx = TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nx;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_id   <= pick_idx;
            hold_cnt <= HW'(1);
          end
        end
        OWN: begin
          if (release_own) begin
            gnt      <= '0;
            hold_cnt <= '0;
            timeout  <= forced;
            rr_ptr   <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state == OWN);
    bus_oe = busy;
    bus_a  = '0;
    if (busy) bus_a = req_data[gnt_id*W +: W];
  end

endmodule

// File: tb/tb_shared_bus_rr_arbiter.sv
// Randomized bench for shared_bus_rr_arbiter against an ownership-level reference model.
module tb_shared_bus_rr_arbiter;

  localparam int NREQ     = 4;
  localparam int BITSA    = 7;
  localparam int MAX_HOLD = 3;
  localparam int W        = BITSA + 1;
  localparam int WAIT_MAX = (NREQ - 1) * (MAX_HOLD + 2) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*W-1:0]     req_data;
  logic [NREQ-1:0]       gnt;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                  busy;
  logic [BITSA:0]        bus_a;
  logic                  bus_oe;
  logic                  timeout;

  always #5 clk = ~clk;

  shared_bus_rr_arbiter #(.NREQ(NREQ), .BITSA(BITSA), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .last     (last),
    .req_data (req_data),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .bus_a    (bus_a),
    .bus_oe   (bus_oe),
    .timeout  (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, for how long, and where the search starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_turn  = 1'b0;
  bit m_tmo   = 1'b0;

  int              run_len = 0;
  int              prev_id = 0;
  bit              prev_oe = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;
  int              waitc [NREQ];

  task automatic step();
    logic [NREQ-1:0] req_s;
    bit              rst_s;
    bit              over;
    int              i;
    @(posedge clk);
    req_s = req;
    rst_s = rst;
    if (rst_s) begin
      m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_tmo = 1'b0; m_held = 0;
    end else if (m_owner >= 0) begin
      if (!req_s[m_owner] || last[m_owner] || m_held == MAX_HOLD) begin
        m_tmo   = req_s[m_owner] && !last[m_owner];
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_turn  = 1'b1;
      end else begin
        m_held++;
        m_tmo = 1'b0;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (req_s[i] && m_owner < 0) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end
    #1;
    check("gnt",     gnt,     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy",    busy,    m_owner >= 0);
    check("bus_oe",  bus_oe,  m_owner >= 0);
    check("bus_a",   bus_a,   (m_owner >= 0) ? req_data[m_owner*W +: W] : '0);
    check("timeout", timeout, m_tmo);
    if (m_owner >= 0) check("gnt_id", gnt_id, m_owner);
    check("onehot0", $onehot0(gnt), 1);
    check("oe_busy", bus_oe & ~busy, 0);
    check("overlap", prev_oe && bus_oe && (int'(gnt_id) != prev_id), 0);
    if (bus_oe && prev_oe && int'(gnt_id) == prev_id) run_len++;
    else run_len = bus_oe ? 1 : 0;
    check("hold_max", run_len > MAX_HOLD, 0);
    over = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (rst_s || !req_s[k] || gnt[k] || prev_gnt[k]) waitc[k] = 0;
      else waitc[k]++;
      if (waitc[k] > WAIT_MAX) over = 1'b1;
    end
    check("wait_max", over, 0);
    prev_oe  = bus_oe;
    prev_id  = int'(gnt_id);
    prev_gnt = gnt;
  endtask

  initial begin
    bit reached;
    for (int k = 0; k < NREQ; k++) waitc[k] = 0;
    rst = 1'b1; req = '0; last = '0; req_data = $urandom;
    step(); step();
    check("rst_gnt_id",  gnt_id,  0);
    check("rst_bus_a",   bus_a,   0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Lone requester held without last: forced releases and re-grants.
    req = 4'b0001;
    repeat (12) step();
    // Everyone requesting, releasing on first OWN cycle.
    req = 4'b1111; last = 4'b1111;
    repeat (16) step();
    // Owner 2 drops its request mid-transfer while 3 is waiting.
    req = 4'b1100; last = '0;
    reached = 1'b0;
    for (int n = 0; n < 30 && !reached; n++) begin
      step();
      if (busy && gnt_id == 2) reached = 1'b1;
    end
    check("reach_own2", reached, 1);
    req = 4'b1000;
    step(); step(); step();
    check("drop_to_3", gnt, 4'b1000);

    // Reset while requester 2 owns the bus.
    req = 4'b0100; last = '0;
    reached = 1'b0;
    for (int n = 0; n < 30 && !reached; n++) begin
      step();
      if (busy && gnt_id == 2) reached = 1'b1;
    end
    check("reach_own2b", reached, 1);
    rst = 1'b1;
    step();
    check("rst_mid_oe", bus_oe, 0);
    rst = 1'b0; req = 4'b0110;
    step();
    check("regrant1", gnt, 4'b0010);

    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < NREQ; k++)
        if ($urandom_range(7) == 0) req[k] = ~req[k];
      last     = NREQ'($urandom & $urandom);
      req_data = $urandom;
      rst      = ($urandom_range(999) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
